// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge_gen pulse-burst generator.
package edge_gen_pkg;

   localparam int unsigned LEN_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // A programmed phase length of zero still occupies one cycle.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_W'(1) : len;
   endfunction

endpackage

// File: rtl/edge_gen_cnt.sv
// Loadable down-counter with zero/one flags; used for phase length and pulse count.
module edge_gen_cnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_is_zero_c,
   output logic             o_is_one_c
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_is_zero_c = (r_cnt == '0);
   assign o_is_one_c  = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/edge_gen.sv
// Programmable pulse-burst generator driving a registered pin with edge strobes.
// Optional EDGE_GEN_CNT_EN adds sent_cnt, the number of completed high phases.
module edge_gen
   import edge_gen_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [CNT_W-1:0] pulse_num,
   output logic             dout,
   output logic             dout_pos_edge,
   output logic             dout_neg_edge,
   output logic             busy,
`ifdef EDGE_GEN_CNT_EN
   output logic [CNT_W-1:0] sent_cnt,
`endif
   output logic             done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_dout;
   logic             r_pos;
   logic             r_neg;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_high_len;
   logic [CNT_W-1:0] r_low_len;

   logic             w_accept;
   logic             w_dout_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_ph_load;
   logic [CNT_W-1:0] w_ph_val;
   logic             w_ph_dec;
   logic             w_ph_zero;
   logic             w_ph_one;
   logic             w_ph_end;
   logic             w_pc_load;
   logic             w_pc_dec;
   logic             w_pc_zero;
   logic             w_pc_one;
   logic             w_pc_last;
   logic [CNT_W-1:0] w_high_clamp;
   logic [CNT_W-1:0] w_low_clamp;

   assign w_high_clamp = CNT_W'(clamp_len(LEN_W'(high_len)));
   assign w_low_clamp  = CNT_W'(clamp_len(LEN_W'(low_len)));
   assign w_accept     = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   // A zero count can only appear defensively; treat it as the final value.
   assign w_ph_end     = w_ph_one || w_ph_zero;
   assign w_pc_last    = w_pc_one || w_pc_zero;

   edge_gen_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_ph_load),
      .i_load_val  (w_ph_val),
      .i_dec       (w_ph_dec),
      .o_is_zero_c (w_ph_zero),
      .o_is_one_c  (w_ph_one)
   );

   edge_gen_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_pc_load),
      .i_load_val  (pulse_num),
      .i_dec       (w_pc_dec),
      .o_is_zero_c (w_pc_zero),
      .o_is_one_c  (w_pc_one)
   );

   // State, counter control and next output levels.
   always_comb begin
      w_state_nxt = r_state;
      w_dout_nxt  = IDLE_LEVEL;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_ph_load   = 1'b0;
      w_ph_val    = '0;
      w_ph_dec    = 1'b0;
      w_pc_load   = 1'b0;
      w_pc_dec    = 1'b0;

      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            w_state_nxt = ST_IDLE;
            if (w_accept) begin
               if (pulse_num == '0) begin
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_HIGH;
                  w_dout_nxt  = ~IDLE_LEVEL;
                  w_busy_nxt  = 1'b1;
                  w_ph_load   = 1'b1;
                  w_ph_val    = w_high_clamp;
                  w_pc_load   = 1'b1;
               end
            end
         end
         ST_HIGH: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_ph_end) begin
               w_state_nxt = ST_LOW;
               w_busy_nxt  = 1'b1;
               w_ph_load   = 1'b1;
               w_ph_val    = r_low_len;
            end else begin
               w_dout_nxt  = ~IDLE_LEVEL;
               w_busy_nxt  = 1'b1;
               w_ph_dec    = 1'b1;
            end
         end
         ST_LOW: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_ph_end && w_pc_last) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
            end else if (w_ph_end) begin
               w_state_nxt = ST_HIGH;
               w_dout_nxt  = ~IDLE_LEVEL;
               w_busy_nxt  = 1'b1;
               w_ph_load   = 1'b1;
               w_ph_val    = r_high_len;
               w_pc_dec    = 1'b1;
            end else begin
               w_busy_nxt  = 1'b1;
               w_ph_dec    = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_dout     <= IDLE_LEVEL;
         r_pos      <= 1'b0;
         r_neg      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_high_len <= '0;
         r_low_len  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= w_dout_nxt;
         r_pos   <= w_dout_nxt && !r_dout;
         r_neg   <= !w_dout_nxt && r_dout;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_high_len <= w_high_clamp;
            r_low_len  <= w_low_clamp;
         end
      end
   end

`ifdef EDGE_GEN_CNT_EN
   logic [CNT_W-1:0] r_sent;
   logic             w_sent_inc;

   // A high phase completes on its high-to-low transition.
   assign w_sent_inc = (r_state == ST_HIGH) && !abort && w_ph_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sent <= '0;
      end else if (w_accept) begin
         r_sent <= '0;
      end else if (w_sent_inc) begin
         r_sent <= r_sent + CNT_W'(1);
      end
   end

   assign sent_cnt = r_sent;
`endif

   assign dout          = r_dout;
   assign dout_pos_edge = r_pos;
   assign dout_neg_edge = r_neg;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: directed steps plus random traffic against a timeline model.
module tb_edge_gen;

   localparam int unsigned CNT_W = 16;
   localparam logic        IDLE   = 1'b0;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W-1:0] pulse_num;
   logic             dout;
   logic             dout_pos_edge;
   logic             dout_neg_edge;
   logic             busy;
   logic             done;
`ifdef EDGE_GEN_CNT_EN
   logic [CNT_W-1:0] sent_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a burst is a timeline indexed by k cycles since acceptance.
   bit m_run  = 1'b0;
   bit m_done = 1'b0;
   bit m_dout = IDLE;
   bit m_pos  = 1'b0;
   bit m_neg  = 1'b0;
   int m_k    = 0;
   int m_h    = 1;
   int m_l    = 1;
   int m_n    = 0;
   int m_sent = 0;

   edge_gen #(.CNT_W(CNT_W), .IDLE_LEVEL(IDLE)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .high_len      (high_len),
      .low_len       (low_len),
      .pulse_num     (pulse_num),
      .dout          (dout),
      .dout_pos_edge (dout_pos_edge),
      .dout_neg_edge (dout_neg_edge),
      .busy          (busy),
`ifdef EDGE_GEN_CNT_EN
      .sent_cnt      (sent_cnt),
`endif
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit st, input bit ab, input bit r, input int h, input int l,
                             input int n);
      bit prev;
      int per;
      prev = m_dout;
      if (r) begin
         m_run  = 1'b0;
         m_done = 1'b0;
         m_dout = IDLE;
         m_sent = 0;
      end else if (m_run) begin
         m_done = 1'b0;
         if (ab) begin
            m_run  = 1'b0;
            m_dout = IDLE;
         end else begin
            m_k++;
            per = m_h + m_l;
            if (m_k == m_n * per) begin
               m_run  = 1'b0;
               m_done = 1'b1;
               m_dout = IDLE;
               m_sent = m_n;
            end else begin
               m_dout = ((m_k % per) < m_h) ? ~IDLE : IDLE;
               m_sent = (m_k / per) + (((m_k % per) >= m_h) ? 1 : 0);
            end
         end
      end else begin
         m_done = 1'b0;
         m_dout = IDLE;
         if (st && !ab) begin
            m_h    = (h == 0) ? 1 : h;
            m_l    = (l == 0) ? 1 : l;
            m_n    = n;
            m_sent = 0;
            m_k    = 0;
            if (n == 0) begin
               m_done = 1'b1;
            end else begin
               m_run  = 1'b1;
               m_dout = ~IDLE;
            end
         end
      end
      m_pos = !r && (m_dout == 1'b1) && (prev == 1'b0);
      m_neg = !r && (m_dout == 1'b0) && (prev == 1'b1);
   endtask

   task automatic cyc(input bit st, input bit ab, input bit r, input int h, input int l,
                      input int n);
      @(negedge clk);
      start     = st;
      abort     = ab;
      rst       = r;
      high_len  = CNT_W'(h);
      low_len   = CNT_W'(l);
      pulse_num = CNT_W'(n);
      @(posedge clk);
      model_edge(st, ab, r, h, l, n);
      #1;
      chk("dout", 32'(dout), 32'(m_dout));
      chk("pos_edge", 32'(dout_pos_edge), 32'(m_pos));
      chk("neg_edge", 32'(dout_neg_edge), 32'(m_neg));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
`ifdef EDGE_GEN_CNT_EN
      chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
`endif
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, 1'b0, 7, 7, 7);
   endtask

   initial begin
      start = 1'b0; abort = 1'b0; rst = 1'b1;
      high_len = '0; low_len = '0; pulse_num = '0;

      // Power-on reset and idle state.
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      idle(2);

      // Reset held three cycles in the middle of a burst.
      cyc(1, 0, 0, 4, 4, 5);
      idle(6);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4, 4, 5);
      idle(4);

      // Nominal burst H=3 L=2 N=2.
      cyc(1, 0, 0, 3, 2, 2);
      idle(12);

      // Start at T+2 is ignored; start in the done cycle T+11 is accepted.
      cyc(1, 0, 0, 3, 2, 2);
      idle(1);
      cyc(1, 0, 0, 1, 1, 1);
      idle(8);
      cyc(1, 0, 0, 3, 2, 2);
      idle(12);

      // Zero lengths clamp to one cycle; zero pulses completes immediately.
      cyc(1, 0, 0, 0, 0, 1);
      idle(4);
      cyc(1, 0, 0, 3, 3, 0);
      idle(3);

      // Abort at T+2 of the nominal burst.
      cyc(1, 0, 0, 3, 2, 2);
      idle(1);
      cyc(0, 1, 0, 3, 2, 2);
      idle(4);

      // Abort together with start in idle starts nothing.
      cyc(1, 1, 0, 2, 2, 2);
      idle(3);

      // Short pulses H=1 L=1 N=3.
      cyc(1, 0, 0, 1, 1, 3);
      idle(9);

      // Random traffic; lengths change every cycle to exercise latching.
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 149) == 0), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end
      idle(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
